// File: rtl/multicycle_control.sv
// Multi-cycle control sequencer for the 4-bit-opcode ISA.
// Drives the shared ALU, memory, PC and register file one state at a time.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opCode,
  input  logic       zero,
  input  logic       memReady,
  output logic       pcWriteEn,
  output logic       irWrite,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       memToReg,
  output logic       regDst,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [2:0] aluOp,
  output logic       pcSource,
  output logic       instrDone,
  output logic       illegalOp,
  output logic [3:0] stateOut
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_ADDR   = 4'd2,
    S_MEM_RD = 4'd3,
    S_WB_MEM = 4'd4,
    S_MEM_WR = 4'd5,
    S_EXEC_R = 4'd6,
    S_WB_R   = 4'd7,
    S_BRANCH = 4'd8
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  state_e state_q;

  logic op_r;
  logic op_lw;
  logic op_sw;
  logic op_bne;
  logic pcWrite;
  logic branch;

  always_comb begin
    op_r   = 1'b0;
    op_lw  = 1'b0;
    op_sw  = 1'b0;
    op_bne = 1'b0;
    case (opCode)
      4'd0, 4'd1, 4'd2,
      4'd6, 4'd7: op_r   = 1'b1;
      4'd8:       op_lw  = 1'b1;
      4'd10:      op_sw  = 1'b1;
      4'd14:      op_bne = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:
          if (memReady) state_q <= S_DECODE;
        S_DECODE:
          if (op_r)                state_q <= S_EXEC_R;
          else if (op_lw || op_sw) state_q <= S_ADDR;
          else if (op_bne)         state_q <= S_BRANCH;
          else                     state_q <= S_FETCH;
        S_ADDR:
          if (op_lw)      state_q <= S_MEM_RD;
          else if (op_sw) state_q <= S_MEM_WR;
          else            state_q <= S_FETCH;
        S_MEM_RD:
          if (memReady) state_q <= S_WB_MEM;
        S_MEM_WR:
          if (memReady) state_q <= S_FETCH;
        S_EXEC_R: state_q <= S_WB_R;
        S_WB_R:   state_q <= S_FETCH;
        S_WB_MEM: state_q <= S_FETCH;
        S_BRANCH: state_q <= S_FETCH;
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  // Reset gates every output combinationally so nothing writes mid-reset.
  always_comb begin
    pcWrite   = 1'b0;
    branch    = 1'b0;
    irWrite   = 1'b0;
    iorD      = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    memToReg  = 1'b0;
    regDst    = 1'b0;
    regWrite  = 1'b0;
    aluSrcA   = 1'b0;
    aluSrcB   = 2'b00;
    aluOp     = 3'b000;
    pcSource  = 1'b0;
    instrDone = 1'b0;
    illegalOp = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          memRead = 1'b1;
          aluSrcB = 2'b01;
          aluOp   = ALU_ADD;
          irWrite = memReady;
          pcWrite = memReady;
        end
        S_DECODE: begin
          aluSrcB = 2'b11;
          aluOp   = ALU_ADD;
          if (!(op_r || op_lw || op_sw || op_bne)) begin
            illegalOp = 1'b1;
            instrDone = 1'b1;
          end
        end
        S_EXEC_R: begin
          aluSrcA = 1'b1;
          aluOp   = opCode[2:0];
        end
        S_WB_R: begin
          regDst    = 1'b1;
          regWrite  = 1'b1;
          instrDone = 1'b1;
        end
        S_ADDR: begin
          aluSrcA = 1'b1;
          aluSrcB = 2'b10;
          aluOp   = ALU_ADD;
        end
        S_MEM_RD: begin
          memRead = 1'b1;
          iorD    = 1'b1;
        end
        S_WB_MEM: begin
          memToReg  = 1'b1;
          regWrite  = 1'b1;
          instrDone = 1'b1;
        end
        S_MEM_WR: begin
          memWrite  = 1'b1;
          iorD      = 1'b1;
          instrDone = memReady;
        end
        S_BRANCH: begin
          aluSrcA   = 1'b1;
          aluOp     = ALU_SUB;
          branch    = 1'b1;
          pcSource  = 1'b1;
          instrDone = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pcWriteEn = pcWrite | (branch & ~zero);
  assign stateOut  = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle vector table
// plus instruction-level sequences for stalls and pulse counts.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opCode;
  logic       zero;
  logic       memReady;
  logic       pcWriteEn, irWrite, iorD, memRead, memWrite;
  logic       memToReg, regDst, regWrite, aluSrcA;
  logic [1:0] aluSrcB;
  logic [2:0] aluOp;
  logic       pcSource, instrDone, illegalOp;
  logic [3:0] stateOut;

  int errors = 0;
  int checks = 0;
  int stall_bad = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opCode(opCode), .zero(zero),
    .memReady(memReady), .pcWriteEn(pcWriteEn), .irWrite(irWrite),
    .iorD(iorD), .memRead(memRead), .memWrite(memWrite),
    .memToReg(memToReg), .regDst(regDst), .regWrite(regWrite),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
    .pcSource(pcSource), .instrDone(instrDone),
    .illegalOp(illegalOp), .stateOut(stateOut)
  );

  // {pcWriteEn,irWrite,iorD,memRead,memWrite,memToReg,regDst,
  //  regWrite,aluSrcA,aluSrcB[1:0],aluOp[2:0],pcSource,instrDone,illegalOp}
  logic [16:0] outs;
  assign outs = {pcWriteEn, irWrite, iorD, memRead, memWrite,
                 memToReg, regDst, regWrite, aluSrcA, aluSrcB,
                 aluOp, pcSource, instrDone, illegalOp};

  localparam logic [16:0] O_ZERO    = 17'd0;
  localparam logic [16:0] O_FETCH_R = 17'b1_1_0_1_0_0_0_0_0_01_010_0_0_0;
  localparam logic [16:0] O_FETCH_W = 17'b0_0_0_1_0_0_0_0_0_01_010_0_0_0;
  localparam logic [16:0] O_DEC     = 17'b0_0_0_0_0_0_0_0_0_11_010_0_0_0;
  localparam logic [16:0] O_DEC_ILL = 17'b0_0_0_0_0_0_0_0_0_11_010_0_1_1;
  localparam logic [16:0] O_EX_ADD  = 17'b0_0_0_0_0_0_0_0_1_00_010_0_0_0;
  localparam logic [16:0] O_EX_OR   = 17'b0_0_0_0_0_0_0_0_1_00_001_0_0_0;
  localparam logic [16:0] O_EX_SLT  = 17'b0_0_0_0_0_0_0_0_1_00_111_0_0_0;
  localparam logic [16:0] O_WBR     = 17'b0_0_0_0_0_0_1_1_0_00_000_0_1_0;
  localparam logic [16:0] O_ADDR    = 17'b0_0_0_0_0_0_0_0_1_10_010_0_0_0;
  localparam logic [16:0] O_MRD     = 17'b0_0_1_1_0_0_0_0_0_00_000_0_0_0;
  localparam logic [16:0] O_WBM     = 17'b0_0_0_0_0_1_0_1_0_00_000_0_1_0;
  localparam logic [16:0] O_MWR_W   = 17'b0_0_1_0_1_0_0_0_0_00_000_0_0_0;
  localparam logic [16:0] O_MWR_D   = 17'b0_0_1_0_1_0_0_0_0_00_000_0_1_0;
  localparam logic [16:0] O_BR_T    = 17'b1_0_0_0_0_0_0_0_1_00_110_1_1_0;
  localparam logic [16:0] O_BR_N    = 17'b0_0_0_0_0_0_0_0_1_00_110_1_1_0;

  typedef struct packed {
    logic        rst;
    logic [3:0]  op;
    logic        z;
    logic        rdy;
    logic [3:0]  st;
    logic [16:0] o;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic r, logic [3:0] op, logic z,
                              logic rdy, logic [3:0] st,
                              logic [16:0] o);
    vec_t v;
    v.rst = r; v.op = op; v.z = z; v.rdy = rdy; v.st = st; v.o = o;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(logic r, logic [3:0] op, logic z, logic rdy);
    @(negedge clk);
    reset = r; opCode = op; zero = z; memReady = rdy;
    #1;
  endtask

  // Runs one instruction from FETCH with `stalls` not-ready fetch cycles.
  task automatic run(input logic [3:0] op, input int stalls,
                     output int n, output int mw, output int rw,
                     output int ill);
    n = 0; mw = 0; rw = 0; ill = 0;
    for (int c = 0; c < 30; c++) begin
      step(1'b0, op, 1'b0, (c >= stalls));
      n++;
      if (c < stalls &&
          !(memRead && !iorD && !irWrite && !pcWriteEn))
        stall_bad++;
      mw += int'(memWrite);
      rw += int'(regWrite);
      ill += int'(illegalOp);
      if (instrDone) break;
    end
  endtask

  initial begin
    int n, mw, rw, ill;
    reset = 1'b1; opCode = 4'd0; zero = 1'b0; memReady = 1'b0;

    tv.push_back(mk(1, 4'd0,  0, 0, 4'd0, O_ZERO));
    tv.push_back(mk(1, 4'd0,  0, 1, 4'd0, O_ZERO));
    // ADD
    tv.push_back(mk(0, 4'd2,  0, 1, 4'd0, O_FETCH_R));
    tv.push_back(mk(0, 4'd2,  0, 1, 4'd1, O_DEC));
    tv.push_back(mk(0, 4'd2,  0, 1, 4'd6, O_EX_ADD));
    tv.push_back(mk(0, 4'd2,  0, 1, 4'd7, O_WBR));
    // LW with two wait cycles in MEM_RD
    tv.push_back(mk(0, 4'd8,  0, 1, 4'd0, O_FETCH_R));
    tv.push_back(mk(0, 4'd8,  0, 1, 4'd1, O_DEC));
    tv.push_back(mk(0, 4'd8,  0, 1, 4'd2, O_ADDR));
    tv.push_back(mk(0, 4'd8,  0, 0, 4'd3, O_MRD));
    tv.push_back(mk(0, 4'd8,  0, 0, 4'd3, O_MRD));
    tv.push_back(mk(0, 4'd8,  0, 1, 4'd3, O_MRD));
    tv.push_back(mk(0, 4'd8,  0, 1, 4'd4, O_WBM));
    // SW
    tv.push_back(mk(0, 4'd10, 0, 1, 4'd0, O_FETCH_R));
    tv.push_back(mk(0, 4'd10, 0, 1, 4'd1, O_DEC));
    tv.push_back(mk(0, 4'd10, 0, 1, 4'd2, O_ADDR));
    tv.push_back(mk(0, 4'd10, 0, 1, 4'd5, O_MWR_D));
    // BNE taken, then not taken
    tv.push_back(mk(0, 4'd14, 0, 1, 4'd0, O_FETCH_R));
    tv.push_back(mk(0, 4'd14, 0, 1, 4'd1, O_DEC));
    tv.push_back(mk(0, 4'd14, 0, 1, 4'd8, O_BR_T));
    tv.push_back(mk(0, 4'd14, 1, 1, 4'd0, O_FETCH_R));
    tv.push_back(mk(0, 4'd14, 1, 1, 4'd1, O_DEC));
    tv.push_back(mk(0, 4'd14, 1, 1, 4'd8, O_BR_N));
    // illegal opcode 3
    tv.push_back(mk(0, 4'd3,  0, 1, 4'd0, O_FETCH_R));
    tv.push_back(mk(0, 4'd3,  0, 1, 4'd1, O_DEC_ILL));
    // OR with two fetch stalls
    tv.push_back(mk(0, 4'd1,  0, 0, 4'd0, O_FETCH_W));
    tv.push_back(mk(0, 4'd1,  0, 0, 4'd0, O_FETCH_W));
    tv.push_back(mk(0, 4'd1,  0, 1, 4'd0, O_FETCH_R));
    tv.push_back(mk(0, 4'd1,  0, 1, 4'd1, O_DEC));
    tv.push_back(mk(0, 4'd1,  0, 1, 4'd6, O_EX_OR));
    tv.push_back(mk(0, 4'd1,  0, 1, 4'd7, O_WBR));
    // SLT
    tv.push_back(mk(0, 4'd7,  0, 1, 4'd0, O_FETCH_R));
    tv.push_back(mk(0, 4'd7,  0, 1, 4'd1, O_DEC));
    tv.push_back(mk(0, 4'd7,  0, 1, 4'd6, O_EX_SLT));
    tv.push_back(mk(0, 4'd7,  0, 1, 4'd7, O_WBR));
    // SW stalled in MEM_WR, then reset held 3 cycles
    tv.push_back(mk(0, 4'd10, 0, 1, 4'd0, O_FETCH_R));
    tv.push_back(mk(0, 4'd10, 0, 1, 4'd1, O_DEC));
    tv.push_back(mk(0, 4'd10, 0, 1, 4'd2, O_ADDR));
    tv.push_back(mk(0, 4'd10, 0, 0, 4'd5, O_MWR_W));
    tv.push_back(mk(0, 4'd10, 0, 0, 4'd5, O_MWR_W));
    tv.push_back(mk(1, 4'd10, 0, 1, 4'd0, O_ZERO));
    tv.push_back(mk(1, 4'd10, 0, 1, 4'd0, O_ZERO));
    tv.push_back(mk(1, 4'd10, 0, 1, 4'd0, O_ZERO));
    tv.push_back(mk(0, 4'd10, 0, 0, 4'd0, O_FETCH_W));

    foreach (tv[i]) begin
      step(tv[i].rst, tv[i].op, tv[i].z, tv[i].rdy);
      checks++;
      if ({stateOut, outs} !== {tv[i].st, tv[i].o}) begin
        errors++;
        $display("FAIL vec%0d: state=%0d outs=%b expected state=%0d outs=%b",
                 i, stateOut, outs, tv[i].st, tv[i].o);
      end
      chk($sformatf("rd_wr_excl%0d", i), int'(memRead & memWrite), 0);
    end

    // LW with three not-ready fetch cycles: 5 + 3 cycles
    run(4'd8, 3, n, mw, rw, ill);
    chk("lw_stall_cycles", n, 8);
    chk("lw_done_state", int'(stateOut), 4);
    chk("lw_regwrite_cnt", rw, 1);
    chk("fetch_stall_stable", stall_bad, 0);

    run(4'd10, 0, n, mw, rw, ill);
    chk("sw_cycles", n, 4);
    chk("sw_memwrite_cnt", mw, 1);
    chk("sw_regwrite_cnt", rw, 0);

    run(4'd0, 0, n, mw, rw, ill);
    chk("and_cycles", n, 4);
    chk("and_regwrite_cnt", rw, 1);

    run(4'd14, 0, n, mw, rw, ill);
    chk("bne_cycles", n, 3);

    run(4'd15, 0, n, mw, rw, ill);
    chk("ill_cycles", n, 2);
    chk("ill_pulse_cnt", ill, 1);
    chk("ill_no_writes", mw + rw, 0);
    step(1'b0, 4'd2, 1'b0, 1'b1);
    chk("ill_then_fetch", int'(stateOut), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
